gift_cofb_rkey_gen: RTL and testbench
=====================================

// Module: gift_cofb_rkey_gen
// PURPOSE
// - Sequential GIFT-128 round-key generator for the GIFT-COFB datapath.
// - Accepts a 128-bit key as four 32-bit beats and iterates the key-state update
//   (rotate/shift of 16-bit halves) for NROUNDS rounds.
// - Emits two 32-bit round-key words per round on a valid/ready stream.
// - Optionally fix-slices each word through the key-arrangement swapmove chain.
// - Feeds the round-key buffer consumed by the GIFT round core.
// PARAMETERS
// - NROUNDS  40  rounds generated per key (legal range 1..63)
// PORTS
// - g_clk       in   1   clock; all state updates on rising edge
// - g_resetn    in   1   asynchronous active-low reset
// - abort       in   1   synchronous flush to IDLE (takes priority over all handshakes)
// - key_valid   in   1   key beat valid
// - key_ready   out  1   key beat accepted when key_valid & key_ready
// - key_data    in   32  key beat; beats 0..3 load W0..W3
// - rk_valid    out  1   round-key word valid
// - rk_ready    in   1   consumer accepts when rk_valid & rk_ready
// - rk_data     out  32  round-key word
// - rk_round    out  6   round index of rk_data, 0..NROUNDS-1
// - rk_last     out  1   high on the final word (round NROUNDS-1, second word)
// - busy        out  1   high in LOAD or RUN
// BEHAVIOUR
// - Reset: state=IDLE; W0..W3=0; all counters 0; outputs key_ready=0, rk_valid=0,
//   rk_data=0, rk_round=0, rk_last=0, busy=0.
// - FSM IDLE -> LOAD on first accepted key beat.
//   - key_ready=1 in IDLE and LOAD.
// - LOAD: 2-bit beat counter.
//   - On the 4th accepted beat -> RUN, round=0, sel=0.
//   - key_valid low stalls without losing loaded beats.
// - RUN: key_ready=0; rk_valid=1 combinationally from state; data registered in W.
//   - sel=0 emits f(W1); sel=1 emits f(W3). f = identity or arrange (see CONFIGURATION).
//   - Handshake on sel=0: sel<=1.
//   - Handshake on sel=1: sel<=0; round<=round+1; state update in the same edge:
//     W3<=W2, W2<=W1, W1<=W0, W0<=ku(W3).
//   - ku(x) = ((x>>12)&0x0000000f) | ((x&0x00000fff)<<4)
//           | ((x>>2)&0x3fff0000)  | ((x&0x00030000)<<14).
//   - Handshake with rk_last=1 -> IDLE; the state update is suppressed.
// - Stall: rk_valid stays high and rk_data/rk_round hold stable while rk_ready=0.
//   - No bubble between words when rk_ready stays high: 1 word/cycle.
// - Latency: first rk_valid in the cycle after the 4th key beat.
//   - Total 4 + 2*NROUNDS cycles at full throughput.
// - key_valid during RUN is ignored: not accepted, key_ready=0.
// - abort in any state: next state IDLE, sel/round/beat counters cleared,
//   W retained but unused.
// - abort together with a handshake: abort wins; the beat is not consumed/loaded.
// - Async reset mid-RUN: immediate return to reset values; no partial output after release.
// CONFIGURATION
// - Macro GIFT_RKEY_ARRANGE_EN.
// - Defined: f(x) = arrange(x, imm = round mod 4).
//   - arrange is four chained swapmoves, sm(x,m,n): t=(x^(x>>n))&m; x^t^(t<<n).
//   - imm0: (00550055,9)  (00003333,18) (000f000f,12) (000000ff,24)
//   - imm1: (11111111,3)  (03030303,6)  (000f000f,12) (000000ff,24)
//   - imm2: (0000aaaa,15) (00003333,18) (0000f0f0,12) (000000ff,24)
//   - imm3: (0a0a0a0a,3)  (00cc00cc,6)  (0000f0f0,12) (000000ff,24)
//   - Combinational on the W register output; latency unchanged.
// - Undefined: f(x)=x; arrangement logic not instantiated.
// TESTING
// - Zero key: load 4x 0x00000000, rk_ready=1 -> 80 words all 0x00000000.
//   rk_last only on word 80; IDLE next cycle.
// - Ordering, macro off: load 11111111,22222222,33333333,44444444.
//   rk_data sequence 22222222,44444444 | 11111111,33333333 | 11114444,22222222.
//   rk_round 0,0,1,1,2,2.
// - Backpressure: same key; rk_ready toggles 1010... and is held low 5 cycles at word 3.
//   Output word stream is identical to the ordering case; rk_data stable while stalled.
// - Abort/reset: abort at round 7 sel=1 together with rk_ready=1.
//   That word is not consumed; IDLE next cycle, busy=0.
//   Reload and restart from round 0. Repeat with g_resetn pulsed low mid-LOAD.
// - Key beats during RUN: key_valid=1 throughout RUN -> key_ready=0.
//   Output stream unchanged vs ordering case.
// - Macro on: key 11111111,22222222,33333333,44444444.
//   Each word equals the software arrange(W, round%4) model for all 80 words.

Source files
------------

// File: rtl/gift_cofb_rkey_gen.sv
// Sequential GIFT-128 round-key generator: loads a 128-bit key in four beats, emits two words per round.
// Optional key-arrangement fix-slicing of each output word is enabled with `define GIFT_RKEY_ARRANGE_EN.
module gift_cofb_rkey_gen #(
    parameter int NROUNDS = 40
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        abort,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [31:0] key_data,
    output logic        rk_valid,
    input  logic        rk_ready,
    output logic [31:0] rk_data,
    output logic [5:0]  rk_round,
    output logic        rk_last,
    output logic        busy
);

    // state | meaning
    // IDLE  | waiting for the first key beat
    // LOAD  | collecting key beats 1..3
    // RUN   | streaming round-key words
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;

    localparam logic [5:0] LAST_ROUND = 6'(NROUNDS - 1);

    logic [1:0]  state_q, state_d;
    logic [1:0]  beat_q, beat_d;
    logic        sel_q, sel_d;
    logic [5:0]  round_q, round_d;
    logic [31:0] w0_q, w1_q, w2_q, w3_q;
    logic [31:0] w0_d, w1_d, w2_d, w3_d;
    logic        key_ready_q, key_ready_d;
    logic        key_acc;
    logic        rk_hs;
    logic [31:0] word_sel;
    logic [31:0] word_out;

    function automatic logic [31:0] key_update(input logic [31:0] x);
        return ((x >> 12) & 32'h0000000f) | ((x & 32'h00000fff) << 4)
             | ((x >> 2) & 32'h3fff0000)  | ((x & 32'h00030000) << 14);
    endfunction

`ifdef GIFT_RKEY_ARRANGE_EN
    function automatic logic [31:0] swapmove(input logic [31:0] x, input logic [31:0] m,
                                             input int n);
        logic [31:0] t;
        t = (x ^ (x >> n)) & m;
        return x ^ t ^ (t << n);
    endfunction

    function automatic logic [31:0] arrange(input logic [31:0] x, input logic [1:0] imm);
        logic [31:0] y;
        y = x;
        case (imm)
            2'd0: begin
                y = swapmove(y, 32'h00550055, 9);
                y = swapmove(y, 32'h00003333, 18);
                y = swapmove(y, 32'h000f000f, 12);
            end
            2'd1: begin
                y = swapmove(y, 32'h11111111, 3);
                y = swapmove(y, 32'h03030303, 6);
                y = swapmove(y, 32'h000f000f, 12);
            end
            2'd2: begin
                y = swapmove(y, 32'h0000aaaa, 15);
                y = swapmove(y, 32'h00003333, 18);
                y = swapmove(y, 32'h0000f0f0, 12);
            end
            default: begin
                y = swapmove(y, 32'h0a0a0a0a, 3);
                y = swapmove(y, 32'h00cc00cc, 6);
                y = swapmove(y, 32'h0000f0f0, 12);
            end
        endcase
        return swapmove(y, 32'h000000ff, 24);
    endfunction
`endif

    assign word_sel = sel_q ? w3_q : w1_q;

`ifdef GIFT_RKEY_ARRANGE_EN
    assign word_out = arrange(word_sel, round_q[1:0]);
`else
    assign word_out = word_sel;
`endif

    assign rk_valid  = (state_q == RUN);
    assign rk_data   = rk_valid ? word_out : 32'h0;
    assign rk_round  = round_q;
    assign rk_last   = rk_valid & sel_q & (round_q == LAST_ROUND);
    assign busy      = (state_q == LOAD) | (state_q == RUN);
    assign key_ready = key_ready_q;

    assign key_acc = key_valid & key_ready_q;
    assign rk_hs   = rk_valid & rk_ready;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        sel_d   = sel_q;
        round_d = round_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        w3_d    = w3_q;
        if (abort) begin
            state_d = IDLE;
            beat_d  = 2'd0;
            sel_d   = 1'b0;
            round_d = 6'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (key_acc) begin
                        w0_d    = key_data;
                        beat_d  = 2'd1;
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    if (key_acc) begin
                        case (beat_q)
                            2'd1:    w1_d = key_data;
                            2'd2:    w2_d = key_data;
                            default: w3_d = key_data;
                        endcase
                        beat_d = beat_q + 2'd1;
                        if (beat_q == 2'd3) begin
                            state_d = RUN;
                            round_d = 6'd0;
                            sel_d   = 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (rk_hs) begin
                        if (!sel_q) begin
                            sel_d = 1'b1;
                        end else if (rk_last) begin
                            // final word: leave W untouched and park the counters
                            state_d = IDLE;
                            sel_d   = 1'b0;
                            round_d = 6'd0;
                        end else begin
                            sel_d   = 1'b0;
                            round_d = round_q + 6'd1;
                            w3_d    = w2_q;
                            w2_d    = w1_q;
                            w1_d    = w0_q;
                            w0_d    = key_update(w3_q);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        key_ready_d = (state_d != RUN);
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q     <= IDLE;
            beat_q      <= 2'd0;
            sel_q       <= 1'b0;
            round_q     <= 6'd0;
            w0_q        <= 32'h0;
            w1_q        <= 32'h0;
            w2_q        <= 32'h0;
            w3_q        <= 32'h0;
            key_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            sel_q       <= sel_d;
            round_q     <= round_d;
            w0_q        <= w0_d;
            w1_q        <= w1_d;
            w2_q        <= w2_d;
            w3_q        <= w3_d;
            key_ready_q <= key_ready_d;
        end
    end

endmodule

// File: tb/tb_gift_cofb_rkey_gen.sv
// Directed bench for gift_cofb_rkey_gen: reset, ordering, backpressure, abort, reset mid-load.
// Follows GIFT_RKEY_ARRANGE_EN so the expected words match the build under test.
module tb_gift_cofb_rkey_gen;

    localparam int NR = 40;
    localparam int NW = 2 * NR;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        abort;
    logic        key_valid;
    logic        key_ready;
    logic [31:0] key_data;
    logic        rk_valid;
    logic        rk_ready;
    logic [31:0] rk_data;
    logic [5:0]  rk_round;
    logic        rk_last;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_w [0:NW-1];
    logic [5:0]  exp_r [0:NW-1];

    gift_cofb_rkey_gen #(.NROUNDS(NR)) dut (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .abort     (abort),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_data  (key_data),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_data   (rk_data),
        .rk_round  (rk_round),
        .rk_last   (rk_last),
        .busy      (busy)
    );

    always #5 g_clk = ~g_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] m_ku(input logic [31:0] x);
        logic [31:0] lo, hi;
        lo = {16'h0, x[3:0], x[15:4]} >> 0;
        lo = {16'h0, x[11:0], x[15:12]};
        hi = {x[17:16], x[31:18], 16'h0};
        return hi | lo;
    endfunction

    function automatic logic [31:0] m_sm(input logic [31:0] x, input logic [31:0] m, input int n);
        logic [31:0] t;
        t = (x ^ (x >> n)) & m;
        return x ^ t ^ (t << n);
    endfunction

    function automatic logic [31:0] m_f(input logic [31:0] x, input int r);
`ifdef GIFT_RKEY_ARRANGE_EN
        logic [31:0] mk [4][4];
        int          sh [4][4];
        logic [31:0] y;
        mk[0] = '{32'h00550055, 32'h00003333, 32'h000f000f, 32'h000000ff};
        mk[1] = '{32'h11111111, 32'h03030303, 32'h000f000f, 32'h000000ff};
        mk[2] = '{32'h0000aaaa, 32'h00003333, 32'h0000f0f0, 32'h000000ff};
        mk[3] = '{32'h0a0a0a0a, 32'h00cc00cc, 32'h0000f0f0, 32'h000000ff};
        sh[0] = '{9, 18, 12, 24};
        sh[1] = '{3, 6, 12, 24};
        sh[2] = '{15, 18, 12, 24};
        sh[3] = '{3, 6, 12, 24};
        y = x;
        for (int s = 0; s < 4; s++) y = m_sm(y, mk[r % 4][s], sh[r % 4][s]);
        return y;
`else
        if (r < 0) return 32'h0;
        return x;
`endif
    endfunction

    task automatic build_exp(input logic [31:0] k0, input logic [31:0] k1,
                             input logic [31:0] k2, input logic [31:0] k3);
        logic [31:0] w [4];
        logic [31:0] nw;
        w[0] = k0; w[1] = k1; w[2] = k2; w[3] = k3;
        for (int r = 0; r < NR; r++) begin
            exp_w[2*r]   = m_f(w[1], r);
            exp_w[2*r+1] = m_f(w[3], r);
            exp_r[2*r]   = 6'(r);
            exp_r[2*r+1] = 6'(r);
            nw   = m_ku(w[3]);
            w[3] = w[2]; w[2] = w[1]; w[1] = w[0]; w[0] = nw;
        end
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic load_key(input logic [31:0] k0, input logic [31:0] k1,
                            input logic [31:0] k2, input logic [31:0] k3, input bit gap);
        logic [31:0] k [4];
        k[0] = k0; k[1] = k1; k[2] = k2; k[3] = k3;
        for (int i = 0; i < 4; i++) begin
            if (gap && i == 2) begin
                key_valid = 1'b0;
                @(posedge g_clk); #1;
                chk("load_stall_busy", 32'(busy), 32'h1);
                chk("load_stall_no_valid", 32'(rk_valid), 32'h0);
            end
            key_valid = 1'b1;
            key_data  = k[i];
            chk($sformatf("key_ready_load[%0d]", i), 32'(key_ready), 32'h1);
            @(posedge g_clk); #1;
        end
        key_valid = 1'b0;
        chk("first_valid_latency", 32'(rk_valid), 32'h1);
        chk("first_round", 32'(rk_round), 32'h0);
    endtask

    // mode 0: rk_ready always high; mode 1: toggling with a 5-cycle hold-off at word 3.
    task automatic run_stream(input int mode, input bit kv_run, input int stop_at);
        int   got;
        int   cyc;
        int   stall_left;
        logic rdy;
        got = 0; cyc = 0; stall_left = 5;
        key_valid = kv_run;
        key_data  = 32'hdeadbeef;
        while (got < NW && got != stop_at && cyc < 1000) begin
            if (mode == 0) rdy = 1'b1;
            else if (got == 3 && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end else rdy = (cyc % 2 == 0);
            rk_ready = rdy;
            chk($sformatf("rk_valid[%0d]", got), 32'(rk_valid), 32'h1);
            chk($sformatf("rk_data[%0d]", got), rk_data, exp_w[got]);
            chk($sformatf("rk_round[%0d]", got), 32'(rk_round), 32'(exp_r[got]));
            chk($sformatf("rk_last[%0d]", got), 32'(rk_last), 32'(got == NW - 1));
            if (kv_run) chk($sformatf("key_ready_run[%0d]", got), 32'(key_ready), 32'h0);
            @(posedge g_clk); #1;
            cyc++;
            if (rdy) got++;
        end
        rk_ready  = 1'b0;
        key_valid = 1'b0;
        chk("stream_within_budget", 32'(cyc < 1000), 32'h1);
        if (stop_at < 0) begin
            chk("end_idle_busy", 32'(busy), 32'h0);
            chk("end_idle_valid", 32'(rk_valid), 32'h0);
            chk("end_idle_key_ready", 32'(key_ready), 32'h1);
        end
    endtask

    task automatic set_order_exp();
        build_exp(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
`ifndef GIFT_RKEY_ARRANGE_EN
        exp_w[0] = 32'h22222222; exp_w[1] = 32'h44444444;
        exp_w[2] = 32'h11111111; exp_w[3] = 32'h33333333;
        exp_w[4] = 32'h11114444; exp_w[5] = 32'h22222222;
`endif
    endtask

    initial begin
        g_resetn  = 1'b0;
        abort     = 1'b0;
        key_valid = 1'b0;
        key_data  = 32'h0;
        rk_ready  = 1'b0;
        #12;
        chk("rst_key_ready", 32'(key_ready), 32'h0);
        chk("rst_rk_valid", 32'(rk_valid), 32'h0);
        chk("rst_rk_data", rk_data, 32'h0);
        chk("rst_rk_round", 32'(rk_round), 32'h0);
        chk("rst_rk_last", 32'(rk_last), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        @(posedge g_clk); #1;
        g_resetn = 1'b1;
        @(posedge g_clk); #1;
        chk("idle_key_ready", 32'(key_ready), 32'h1);

        // zero key
        build_exp(32'h0, 32'h0, 32'h0, 32'h0);
        load_key(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        run_stream(0, 1'b0, -1);

        // ordering with a stalled load beat
        set_order_exp();
        load_key(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 1'b1);
        run_stream(0, 1'b0, -1);

        // backpressure
        load_key(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 1'b0);
        run_stream(1, 1'b0, -1);

        // key beats offered throughout RUN
        load_key(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 1'b0);
        run_stream(0, 1'b1, -1);

        // abort at round 7, second word, with rk_ready high
        load_key(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 1'b0);
        run_stream(0, 1'b0, 15);
        chk("abort_pre_round", 32'(rk_round), 32'h7);
        chk("abort_pre_data", rk_data, exp_w[15]);
        abort    = 1'b1;
        rk_ready = 1'b1;
        @(posedge g_clk); #1;
        abort    = 1'b0;
        rk_ready = 1'b0;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_valid", 32'(rk_valid), 32'h0);
        chk("abort_round", 32'(rk_round), 32'h0);
        chk("abort_key_ready", 32'(key_ready), 32'h1);

        // abort beats a key handshake in IDLE
        abort     = 1'b1;
        key_valid = 1'b1;
        key_data  = 32'hcafef00d;
        @(posedge g_clk); #1;
        abort     = 1'b0;
        key_valid = 1'b0;
        chk("abort_key_not_loaded", 32'(busy), 32'h0);
        load_key(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 1'b0);
        run_stream(0, 1'b0, -1);

        // async reset mid-LOAD
        key_valid = 1'b1;
        key_data  = 32'h99999999;
        @(posedge g_clk); #1;
        key_data  = 32'h88888888;
        @(posedge g_clk); #1;
        chk("midload_busy", 32'(busy), 32'h1);
        key_valid = 1'b0;
        g_resetn  = 1'b0;
        #2;
        chk("midload_rst_busy", 32'(busy), 32'h0);
        chk("midload_rst_key_ready", 32'(key_ready), 32'h0);
        chk("midload_rst_valid", 32'(rk_valid), 32'h0);
        @(posedge g_clk); #1;
        g_resetn = 1'b1;
        @(posedge g_clk); #1;
        chk("post_rst_busy", 32'(busy), 32'h0);
        chk("post_rst_valid", 32'(rk_valid), 32'h0);
        load_key(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 1'b0);
        run_stream(0, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
